// File: rtl/buzzer_melody_sequencer_if.sv
// Button-in / tone-out bundle between the button front end, the melody sequencer and the buzzer PWM.
interface buzzer_melody_sequencer_if;
    logic [3:0]  i_btn;
    logic [15:0] o_freq;
    logic        o_en;
    logic        o_busy;
    logic [1:0]  o_melody;
    logic        o_done;

    modport master (output i_btn, input o_freq, o_en, o_busy, o_melody, o_done);
    modport slave  (input i_btn, output o_freq, o_en, o_busy, o_melody, o_done);
endinterface

// File: rtl/buzzer_melody_sequencer.sv
// Plays one of three fixed note sequences on a button rising edge and drives the
// tone generator's frequency/enable pair; a fourth button stops playback.
module buzzer_melody_sequencer #(
    parameter int unsigned UNIT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    buzzer_melody_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam logic [31:0] GAP_TERM = 32'(GAP_CYCLES - 1);

    // Entry layout: {last, dur[1:0], freq[15:0]}; freq 0 would be a rest.
    function automatic logic [18:0] rom_entry(input logic [1:0] mel, input logic [1:0] idx);
        rom_entry = '0;
        case ({mel, idx})
            4'b00_00: rom_entry = {1'b0, 2'd0, 16'd1046};
            4'b00_01: rom_entry = {1'b0, 2'd0, 16'd1318};
            4'b00_10: rom_entry = {1'b1, 2'd1, 16'd1569};
            4'b01_00: rom_entry = {1'b0, 2'd0, 16'd1569};
            4'b01_01: rom_entry = {1'b0, 2'd0, 16'd1318};
            4'b01_10: rom_entry = {1'b1, 2'd1, 16'd1046};
            4'b10_00: rom_entry = {1'b0, 2'd0, 16'd1046};
            4'b10_01: rom_entry = {1'b0, 2'd0, 16'd1046};
            4'b10_10: rom_entry = {1'b0, 2'd0, 16'd1569};
            4'b10_11: rom_entry = {1'b1, 2'd1, 16'd1569};
            default:  rom_entry = '0;
        endcase
    endfunction

    state_t      r_state, w_state_next;
    logic [31:0] r_cnt, w_cnt_next;
    logic [1:0]  r_note_idx, w_note_idx_next;
    logic [3:0]  r_btn_prev;
    logic [15:0] r_freq, w_freq_next;
    logic        r_en, w_en_next;
    logic        r_busy, w_busy_next;
    logic [1:0]  r_melody, w_melody_next;
    logic        r_done, w_done_next;

    logic [3:0]  w_rise;
    logic        w_start;
    logic [1:0]  w_sel;
    logic [2:0]  w_cur_ctrl;
    logic [15:0] w_first_freq;
    logic [15:0] w_next_freq;
    logic [31:0] w_play_term;

    assign w_rise       = bus.i_btn & ~r_btn_prev;
    assign w_start      = |w_rise[2:0];
    assign w_sel        = w_rise[0] ? 2'd0 : (w_rise[1] ? 2'd1 : 2'd2);
    assign w_cur_ctrl   = 3'(rom_entry(r_melody, r_note_idx) >> 16);
    assign w_first_freq = 16'(rom_entry(w_sel, 2'd0));
    assign w_next_freq  = 16'(rom_entry(r_melody, r_note_idx + 2'd1));
    assign w_play_term  = ({30'd0, w_cur_ctrl[1:0]} + 32'd1) * UNIT_CYCLES - 32'd1;

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_note_idx_next = r_note_idx;
        w_freq_next     = r_freq;
        w_en_next       = r_en;
        w_busy_next     = r_busy;
        w_melody_next   = r_melody;
        w_done_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_melody_next   = w_sel;
                    w_note_idx_next = 2'd0;
                    w_cnt_next      = 32'd0;
                    w_freq_next     = w_first_freq;
                    w_en_next       = (w_first_freq != 16'd0);
                    w_busy_next     = 1'b1;
                    w_state_next    = S_PLAY;
                end
            end
            S_PLAY, S_GAP: begin
                // Stop outranks any count terminal reached in the same cycle.
                if (w_rise[3]) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 32'd0;
                    w_en_next    = 1'b0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else if (r_state == S_PLAY) begin
                    if (r_cnt == w_play_term) begin
                        w_cnt_next   = 32'd0;
                        w_en_next    = 1'b0;
                        w_state_next = S_GAP;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end else if (r_cnt == GAP_TERM) begin
                    w_cnt_next = 32'd0;
                    if (w_cur_ctrl[2]) begin
                        w_state_next = S_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_note_idx_next = r_note_idx + 2'd1;
                        w_freq_next     = w_next_freq;
                        w_en_next       = (w_next_freq != 16'd0);
                        w_state_next    = S_PLAY;
                    end
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_note_idx <= '0;
            r_btn_prev <= '0;
            r_freq     <= '0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_melody   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_note_idx <= w_note_idx_next;
            r_btn_prev <= bus.i_btn;
            r_freq     <= w_freq_next;
            r_en       <= w_en_next;
            r_busy     <= w_busy_next;
            r_melody   <= w_melody_next;
            r_done     <= w_done_next;
        end
    end

    assign bus.o_freq   = r_freq;
    assign bus.o_en     = r_en;
    assign bus.o_busy   = r_busy;
    assign bus.o_melody = r_melody;
    assign bus.o_done   = r_done;
endmodule

// File: tb/tb_buzzer_melody_sequencer.sv
// Directed bench for the melody sequencer with short note/gap timing (UNIT=10, GAP=2).
module tb_buzzer_melody_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    buzzer_melody_sequencer_if bif();

    buzzer_melody_sequencer #(.UNIT_CYCLES(10), .GAP_CYCLES(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got still running, expected finish");
        $fatal(1, "watchdog");
    end

    // Hand-written melody tables: note frequencies and note lengths in clocks.
    int mel_freq [3][4] = '{'{1046, 1318, 1569, 0}, '{1569, 1318, 1046, 0}, '{1046, 1046, 1569, 1569}};
    int mel_len  [3][4] = '{'{10, 10, 20, 0},       '{10, 10, 20, 0},       '{10, 10, 10, 20}};
    int mel_n    [3]    = '{3, 3, 4};

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press, then watch every note and gap of melody m through to the o_done pulse.
    task automatic run_melody(input int m, input logic [3:0] press, input bit hold,
                              input int poke_note, input int poke_cyc, input logic [3:0] poke_val);
        int good;
        bif.i_btn = press;
        tick();
        if (!hold) bif.i_btn = 4'd0;
        check_val($sformatf("m%0d start melody", m), int'(bif.o_melody), m);
        check_val($sformatf("m%0d start busy", m), int'(bif.o_busy), 1);
        for (int n = 0; n < mel_n[m]; n++) begin
            good = 0;
            for (int i = 0; i < mel_len[m][n]; i++) begin
                if (bif.o_en === 1'b1 && int'(bif.o_freq) == mel_freq[m][n]) good++;
                if (n == poke_note && i == poke_cyc) bif.i_btn = poke_val;
                else if (!hold) bif.i_btn = 4'd0;
                tick();
            end
            check_val($sformatf("m%0d note%0d on-cycles f=%0d", m, n, mel_freq[m][n]), good, mel_len[m][n]);
            good = 0;
            for (int i = 0; i < 2; i++) begin
                if (!hold) bif.i_btn = 4'd0;
                if (bif.o_en === 1'b0 && bif.o_busy === 1'b1 && bif.o_done === 1'b0) good++;
                tick();
            end
            if (n == mel_n[m] - 1) good = (good > 0) ? good : good; // last gap ends at the done edge
            check_val($sformatf("m%0d gap%0d silent-cycles", m, n), good, 2);
        end
        check_val($sformatf("m%0d done pulse", m), int'(bif.o_done), 1);
        check_val($sformatf("m%0d busy after", m), int'(bif.o_busy), 0);
        tick();
        check_val($sformatf("m%0d done cleared", m), int'(bif.o_done), 0);
        check_val($sformatf("m%0d en idle", m), int'(bif.o_en), 0);
    endtask

    initial begin
        int cnt;
        bif.i_btn = 4'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset freq", int'(bif.o_freq), 0);
        check_val("reset en", int'(bif.o_en), 0);
        check_val("reset busy", int'(bif.o_busy), 0);
        check_val("reset melody", int'(bif.o_melody), 0);
        check_val("reset done", int'(bif.o_done), 0);
        rst = 1'b0;
        tick();

        // 1: plain melody 0
        run_melody(0, 4'b0001, 1'b0, -1, 0, 4'd0);
        check_val("idle holds freq", int'(bif.o_freq), 1569);

        // 2: btn0 and btn2 together -> melody 0 wins
        run_melody(0, 4'b0101, 1'b0, -1, 0, 4'd0);

        // 3: melody 2 with a btn1 rise mid-note that must be ignored
        run_melody(2, 4'b0100, 1'b0, 1, 4, 4'b0010);
        check_val("m2 melody after ignored btn1", int'(bif.o_melody), 2);

        // 4: stop during the second note of melody 1
        bif.i_btn = 4'b0010;
        tick();
        bif.i_btn = 4'd0;
        repeat (12) tick();
        check_val("m1 second note freq", int'(bif.o_freq), 1318);
        check_val("m1 second note en", int'(bif.o_en), 1);
        repeat (3) tick();
        bif.i_btn = 4'b1000;
        tick();
        bif.i_btn = 4'd0;
        check_val("stop en", int'(bif.o_en), 0);
        check_val("stop done", int'(bif.o_done), 1);
        check_val("stop busy", int'(bif.o_busy), 0);
        tick();
        check_val("stop done single", int'(bif.o_done), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bif.o_en === 1'b0 && bif.o_busy === 1'b0 && bif.o_done === 1'b0) cnt++;
            tick();
        end
        check_val("stopped stays idle", cnt, 15);
        run_melody(1, 4'b0010, 1'b0, -1, 0, 4'd0);

        // 5: hold btn0 through the melody -> no replay
        run_melody(0, 4'b0001, 1'b1, -1, 0, 4'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bif.o_busy === 1'b0 && bif.o_en === 1'b0) cnt++;
            tick();
        end
        check_val("held btn no replay", cnt, 20);
        bif.i_btn = 4'd0;
        tick();

        // 6: async reset during a gap of melody 1
        bif.i_btn = 4'b0010;
        tick();
        bif.i_btn = 4'd0;
        repeat (10) tick();
        check_val("pre-reset in gap busy", int'(bif.o_busy), 1);
        check_val("pre-reset in gap en", int'(bif.o_en), 0);
        #2 rst = 1'b1;
        #1;
        check_val("async reset freq", int'(bif.o_freq), 0);
        check_val("async reset busy", int'(bif.o_busy), 0);
        check_val("async reset melody", int'(bif.o_melody), 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bif.o_done === 1'b1) cnt++;
            tick();
        end
        check_val("async reset no done", cnt, 0);
        rst = 1'b0;
        tick();
        run_melody(2, 4'b0100, 1'b0, -1, 0, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
